// File: rtl/cpu_mem_responder_pkg.sv
// Shared types and default sizes for the cpu memory responder.
package cpu_mem_responder_pkg;

    localparam int unsigned CODE_AW_DEF = 13;
    localparam int unsigned DATA_AW_DEF = 5;
    localparam int unsigned DW_DEF      = 32;
    localparam int unsigned ADDR_W      = 32;

    typedef enum logic {
        ST_LOAD = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/cpu_mem_responder_mem_word_array.sv
// Word-addressed memory: one write port, one registered read port with enable.
// A forced-zero read returns 0 instead of array contents (out-of-range access).
module cpu_mem_responder_mem_word_array #(
    parameter int unsigned AW = 5,
    parameter int unsigned DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic          re_i,
    input  logic          rzero_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);

    localparam int unsigned DEPTH = 1 << AW;

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] rdata_q;

    // Array contents survive reset.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= rzero_i ? '0 : mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/cpu_mem_responder.sv
// Memory-side responder for the cpu: boot-loads code memory, then serves
// instruction fetches; the data port is live in both phases.
module cpu_mem_responder
    import cpu_mem_responder_pkg::*;
#(
    parameter int unsigned CODE_AW = CODE_AW_DEF,
    parameter int unsigned DATA_AW = DATA_AW_DEF,
    parameter int unsigned DW      = DW_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_valid,
    input  logic [DW-1:0]     load_data,
    input  logic              load_last,
    output logic              load_ready,
    input  logic [ADDR_W-1:0] code_addr,
    output logic [DW-1:0]     code_data,
    output logic              code_rdl,
    input  logic              ram_r_en,
    input  logic              ram_w_en,
    input  logic [ADDR_W-1:0] ram_wr_addr,
    input  logic [DW-1:0]     ram_w_data,
    output logic [DW-1:0]     ram_r_data
);

    state_e               state_q, state_d;
    logic [CODE_AW-1:0]   load_ptr_q, load_ptr_d;
    logic                 code_we;
    logic                 code_full;
    logic                 code_oor;
    logic                 data_oor;
    logic                 data_we;

    assign code_full = (load_ptr_q == {CODE_AW{1'b1}});
    assign code_oor  = |code_addr[ADDR_W-1:CODE_AW];
    assign data_oor  = |ram_wr_addr[ADDR_W-1:DATA_AW];
    // Read wins a simultaneous request; out-of-range writes are dropped.
    assign data_we   = ram_w_en & ~ram_r_en & ~data_oor;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_LOAD;
            load_ptr_q <= '0;
        end else begin
            state_q    <= state_d;
            load_ptr_q <= load_ptr_d;
        end
    end

    // Pointer saturates at the last word; filling memory ends the load.
    always_comb begin
        state_d    = state_q;
        load_ptr_d = load_ptr_q;
        code_we    = 1'b0;
        case (state_q)
            ST_LOAD: begin
                if (load_valid) begin
                    code_we = 1'b1;
                    if (load_last || code_full) begin
                        state_d = ST_RUN;
                    end else begin
                        load_ptr_d = load_ptr_q + CODE_AW'(1);
                    end
                end
            end
            ST_RUN: begin
                state_d = ST_RUN;
            end
        endcase
    end

    assign load_ready = (state_q == ST_LOAD);
    assign code_rdl   = (state_q == ST_RUN);

    cpu_mem_responder_mem_word_array #(
        .AW (CODE_AW),
        .DW (DW)
    ) u_code_mem (
        .clk     (clk),
        .rst     (rst),
        .we_i    (code_we),
        .waddr_i (load_ptr_q),
        .wdata_i (load_data),
        .re_i    (state_q == ST_RUN),
        .rzero_i (code_oor),
        .raddr_i (code_addr[CODE_AW-1:0]),
        .rdata_o (code_data)
    );

    cpu_mem_responder_mem_word_array #(
        .AW (DATA_AW),
        .DW (DW)
    ) u_data_mem (
        .clk     (clk),
        .rst     (rst),
        .we_i    (data_we),
        .waddr_i (ram_wr_addr[DATA_AW-1:0]),
        .wdata_i (ram_w_data),
        .re_i    (ram_r_en),
        .rzero_i (data_oor),
        .raddr_i (ram_wr_addr[DATA_AW-1:0]),
        .rdata_o (ram_r_data)
    );

endmodule

// File: tb/tb_cpu_mem_responder.sv
// Self-checking bench for cpu_mem_responder: directed scenarios plus random
// traffic compared every cycle against a behavioural memory model.
module tb_cpu_mem_responder;

    localparam int CODE_AW    = 13;
    localparam int DATA_AW    = 5;
    localparam int CODE_DEPTH = 1 << CODE_AW;
    localparam int DATA_DEPTH = 1 << DATA_AW;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load_valid = 1'b0;
    logic        load_last = 1'b0;
    logic        ram_r_en = 1'b0;
    logic        ram_w_en = 1'b0;
    logic [31:0] load_data = '0;
    logic [31:0] code_addr = '0;
    logic [31:0] ram_wr_addr = '0;
    logic [31:0] ram_w_data = '0;
    logic        load_ready;
    logic        code_rdl;
    logic [31:0] code_data;
    logic [31:0] ram_r_data;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    cpu_mem_responder #(
        .CODE_AW (CODE_AW),
        .DATA_AW (DATA_AW),
        .DW      (32)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .load_valid  (load_valid),
        .load_data   (load_data),
        .load_last   (load_last),
        .load_ready  (load_ready),
        .code_addr   (code_addr),
        .code_data   (code_data),
        .code_rdl    (code_rdl),
        .ram_r_en    (ram_r_en),
        .ram_w_en    (ram_w_en),
        .ram_wr_addr (ram_wr_addr),
        .ram_w_data  (ram_w_data),
        .ram_r_data  (ram_r_data)
    );

    // Behavioural model: memories as arrays with "known" flags.
    bit [31:0] code_m [CODE_DEPTH];
    bit        code_k [CODE_DEPTH];
    bit [31:0] data_m [DATA_DEPTH];
    bit        data_k [DATA_DEPTH];
    bit        m_run = 1'b0;
    int        m_ptr = 0;
    bit [31:0] m_cd = '0;
    bit [31:0] m_rd = '0;
    bit        m_cd_k = 1'b1;
    bit        m_rd_k = 1'b1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_run = 1'b0; m_ptr = 0;
            m_cd = '0; m_cd_k = 1'b1;
            m_rd = '0; m_rd_k = 1'b1;
        end else begin
            if (m_run) begin
                if (code_addr >= 32'(CODE_DEPTH)) begin
                    m_cd = '0; m_cd_k = 1'b1;
                end else begin
                    m_cd = code_m[code_addr]; m_cd_k = code_k[code_addr];
                end
            end
            if (ram_r_en) begin
                if (ram_wr_addr >= 32'(DATA_DEPTH)) begin
                    m_rd = '0; m_rd_k = 1'b1;
                end else begin
                    m_rd = data_m[ram_wr_addr]; m_rd_k = data_k[ram_wr_addr];
                end
            end else if (ram_w_en && ram_wr_addr < 32'(DATA_DEPTH)) begin
                data_m[ram_wr_addr] = ram_w_data;
                data_k[ram_wr_addr] = 1'b1;
            end
            if (!m_run && load_valid) begin
                code_m[m_ptr] = load_data;
                code_k[m_ptr] = 1'b1;
                if (load_last || m_ptr == CODE_DEPTH - 1) m_run = 1'b1;
                else m_ptr++;
            end
        end
    end

    // Compare on the falling edge, away from the active edge.
    always @(negedge clk) begin
        chk("load_ready", {31'b0, load_ready}, {31'b0, ~m_run});
        chk("code_rdl", {31'b0, code_rdl}, {31'b0, m_run});
        if (m_cd_k) chk("code_data", code_data, m_cd);
        if (m_rd_k) chk("ram_r_data", ram_r_data, m_rd);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        load_valid = 1'b0; load_last = 1'b0;
        ram_r_en = 1'b0; ram_w_en = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic load_word(input logic [31:0] d, input logic last);
        load_valid = 1'b1; load_data = d; load_last = last;
        tick();
        load_valid = 1'b0; load_last = 1'b0;
    endtask

    task automatic fetch_chk(input string name, input logic [31:0] a, input logic [31:0] exp);
        code_addr = a;
        tick();
        chk(name, code_data, exp);
    endtask

    task automatic ram_op(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
        ram_r_en = r; ram_w_en = w; ram_wr_addr = a; ram_w_data = d;
        tick();
        ram_r_en = 1'b0; ram_w_en = 1'b0;
    endtask

    function automatic logic [31:0] fill_word(input int i);
        return (32'(i) * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    endfunction

    initial begin
        logic [31:0] t1 [4];
        int n, acc;
        t1 = '{32'h11, 32'h22, 32'h33, 32'h44};

        // Reset values
        tick(); tick();
        chk("rst_ready", {31'b0, load_ready}, 32'd1);
        chk("rst_rdl", {31'b0, code_rdl}, 32'd0);
        chk("rst_code_data", code_data, 32'd0);
        chk("rst_ram_r_data", ram_r_data, 32'd0);
        rst = 1'b0;

        // Basic four-word load, then fetch
        for (int i = 0; i < 4; i++) begin
            load_word(t1[i], i == 3);
            if (i == 2) chk("t1_still_loading", {31'b0, load_ready}, 32'd1);
        end
        chk("t1_ready_fell", {31'b0, load_ready}, 32'd0);
        chk("t1_rdl_rose", {31'b0, code_rdl}, 32'd1);
        fetch_chk("t1_fetch2", 32'd2, 32'h33);

        // Load with a three-cycle gap, then junk load_valid in RUN
        do_reset();
        for (int i = 0; i < 6; i++) begin
            load_word(32'h100 + 32'(i), i == 5);
            if (i == 2) begin tick(); tick(); tick(); end
        end
        for (int i = 0; i < 3; i++) load_word(32'hBAD0_0000 + 32'(i), 1'b0);
        for (int i = 0; i < 6; i++) fetch_chk("t2_contig", 32'(i), 32'h100 + 32'(i));
        chk("t2_run_ready", {31'b0, load_ready}, 32'd0);

        // Fill all of code memory without load_last; the extra word is ignored
        do_reset();
        load_valid = 1'b1; load_last = 1'b0;
        for (int i = 0; i < CODE_DEPTH; i++) begin
            load_data = fill_word(i);
            tick();
            if (i == CODE_DEPTH - 2) chk("t3_not_full", {31'b0, load_ready}, 32'd1);
        end
        chk("t3_full_rdl", {31'b0, code_rdl}, 32'd1);
        load_data = 32'hFFFF_FFFF;
        tick();
        load_valid = 1'b0;
        fetch_chk("t3_last_word", 32'(CODE_DEPTH - 1), fill_word(CODE_DEPTH - 1));
        fetch_chk("t3_first_word", 32'd0, fill_word(0));

        // Data write/read, read priority, hold when idle
        ram_op(1'b0, 1'b1, 32'd5, 32'hDEAD_BEEF);
        ram_op(1'b1, 1'b0, 32'd5, 32'd0);
        chk("t4_rd_after_wr", ram_r_data, 32'hDEAD_BEEF);
        ram_op(1'b1, 1'b1, 32'd5, 32'd1);
        chk("t4_rw_reads", ram_r_data, 32'hDEAD_BEEF);
        ram_op(1'b0, 1'b1, 32'd6, 32'h77);
        chk("t4_hold", ram_r_data, 32'hDEAD_BEEF);
        ram_op(1'b1, 1'b0, 32'd5, 32'd0);
        chk("t4_w_dropped", ram_r_data, 32'hDEAD_BEEF);

        // Out-of-range data and code addresses
        ram_op(1'b0, 1'b1, 32'd0, 32'h1234_5678);
        ram_op(1'b1, 1'b0, 32'h40, 32'd0);
        chk("t5_oor_read", ram_r_data, 32'd0);
        ram_op(1'b0, 1'b1, 32'h40, 32'h55);
        ram_op(1'b1, 1'b0, 32'd0, 32'd0);
        chk("t5_oor_write", ram_r_data, 32'h1234_5678);
        fetch_chk("t5_code_oor", 32'h2000, 32'd0);

        // Reset mid-load, reload, then reset in RUN
        do_reset();
        load_word(32'h5A, 1'b0);
        load_word(32'h5B, 1'b0);
        do_reset();
        load_word(32'hAA, 1'b0);
        load_word(32'hBB, 1'b1);
        fetch_chk("t6_word0", 32'd0, 32'hAA);
        fetch_chk("t6_word1", 32'd1, 32'hBB);
        ram_op(1'b1, 1'b0, 32'd5, 32'd0);
        #2 rst = 1'b1;
        #1;
        chk("t6_async_rdl", {31'b0, code_rdl}, 32'd0);
        chk("t6_async_ready", {31'b0, load_ready}, 32'd1);
        chk("t6_async_code", code_data, 32'd0);
        chk("t6_async_ram", ram_r_data, 32'd0);
        tick();
        rst = 1'b0;

        // Random load followed by random traffic
        n = int'($urandom_range(1, 40));
        acc = 0;
        while (acc < n) begin
            load_valid = ($urandom % 4) != 0;
            load_data = $urandom;
            load_last = (acc == n - 1);
            tick();
            if (load_valid) acc++;
        end
        load_valid = 1'b0; load_last = 1'b0;
        for (int c = 0; c < 400; c++) begin
            ram_r_en = ($urandom % 3) == 0;
            ram_w_en = ($urandom % 2) == 0;
            ram_wr_addr = (($urandom % 8) == 0) ? 32'($urandom_range(32, 1000)) : 32'($urandom % 32);
            ram_w_data = $urandom;
            code_addr = (($urandom % 16) == 0) ? 32'h2000 + 32'($urandom % 100)
                                               : 32'($urandom % CODE_DEPTH);
            load_valid = ($urandom % 4) == 0;
            load_data = $urandom;
            tick();
        end
        ram_r_en = 1'b0; ram_w_en = 1'b0; load_valid = 1'b0;
        tick(); tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
